// File: rtl/alu32.sv
// 32-bit integer ALU: combinational result/flags from a, b, op, plus a
// registered copy of both for pipelined consumers.
module alu32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  op,
    input  logic [7:0]  flags_in,
    output logic [31:0] result,
    output logic [7:0]  flags_out,
    output logic [31:0] result_q,
    output logic [7:0]  flags_q
);

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_AND = 6'h02;
    localparam logic [5:0] OP_OR  = 6'h03;
    localparam logic [5:0] OP_XOR = 6'h04;
    localparam logic [5:0] OP_NOT = 6'h05;
    localparam logic [5:0] OP_SHL = 6'h06;
    localparam logic [5:0] OP_SHR = 6'h07;
    localparam logic [5:0] OP_MUL = 6'h08;
    localparam logic [5:0] OP_DIV = 6'h09;
    localparam logic [5:0] OP_MOD = 6'h0A;
    localparam logic [5:0] OP_CMP = 6'h0B;
    localparam logic [5:0] OP_SAR = 6'h0C;

    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DATA_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

    // N and V are derived from the top two result bits, not from the arithmetic.
    function automatic logic [3:0] std_flags(input logic [DATA_W-1:0] r, input logic c);
        logic z, n, v;
        z = (r == '0);
        n = r[31] & r[30];
        v = r[31] & ~r[30];
        return {v, n, z, c};
    endfunction

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    assign a_s = a;
    assign b_s = b;

    logic [DATA_W-1:0] res;
    logic              c;
    logic              is_cmp;
    logic              is_undef;
    logic [63:0]       prod;
    logic [DATA_W:0]   wide;
    logic signed [DATA_W:0] sar_t;

    always_comb begin
        res      = '0;
        c        = 1'b0;
        is_cmp   = 1'b0;
        is_undef = 1'b0;
        prod     = '0;
        wide     = '0;
        sar_t    = '0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            OP_SUB: begin
                res = a - b;
                c   = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            // Extra bit beyond the word catches the last bit shifted out; n=0 leaves it 0.
            OP_SHL: begin
                wide = {1'b0, a} << b[4:0];
                res  = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            OP_SHR: begin
                wide = {a, 1'b0} >> b[4:0];
                res  = wide[DATA_W:1];
                c    = wide[0];
            end
            OP_SAR: begin
                sar_t = $signed({a, 1'b0}) >>> b[4:0];
                res   = sar_t[DATA_W:1];
                c     = sar_t[0];
            end
            OP_MUL: begin
                prod = {32'h0, a} * {32'h0, b};
                res  = prod[DATA_W-1:0];
                c    = |prod[63:32];
            end
            OP_DIV: begin
                if (b == '0) begin
                    res = ALL_ONES;
                    c   = 1'b1;
                end else if (a == INT_MIN && b == ALL_ONES) begin
                    res = INT_MIN;
                end else begin
                    res = a_s / b_s;
                end
            end
            OP_MOD: begin
                if (b == '0) begin
                    c = 1'b1;
                end else if (!(a == INT_MIN && b == ALL_ONES)) begin
                    res = a_s % b_s;
                end
            end
            OP_CMP: begin
                res    = a;
                c      = (a_s < b_s);
                is_cmp = 1'b1;
            end
            default: is_undef = 1'b1;
        endcase
    end

    always_comb begin
        if (is_undef) begin
            flags_out = flags_in;
        end else if (is_cmp) begin
            flags_out = {flags_in[7:4], 3'b000, c};
        end else begin
            flags_out = {flags_in[7:4], std_flags(res, c)};
        end
    end

    assign result = res;

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result;
            flags_q  <= flags_out;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Directed self-checking bench for alu32: per-opcode vectors, CMP, undefined
// opcodes, registered outputs and asynchronous reset.
module tb_alu32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [7:0]  flags_in;
    logic [31:0] result;
    logic [7:0]  flags_out;
    logic [31:0] result_q;
    logic [7:0]  flags_q;

    int checks;
    int failures;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [7:0]  f;
    } vec_t;

    alu32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .flags_in  (flags_in),
        .result    (result),
        .flags_out (flags_out),
        .result_q  (result_q),
        .flags_q   (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [7:0] fi);
        @(negedge clk);
        op       = o;
        a        = x;
        b        = y;
        flags_in = fi;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(6'h00, 32'd10, 32'd5, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h0 || flags_q !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: result_q=%h flags_q=%h required 00000000/00", result_q, flags_q);
        end
        checks++;
        if (result !== 32'd15) begin
            failures++;
            $display("FAIL reset_comb: result=%h required 0000000f", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub_logic();
        vec_t v[10];
        v[0] = '{6'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,         8'h03};
        v[1] = '{6'h00, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 8'h08};
        v[2] = '{6'h00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 8'h01};
        v[3] = '{6'h00, 32'd10,        32'd5,         32'd15,        8'h00};
        v[4] = '{6'h01, 32'h0,         32'h1,         32'hFFFF_FFFF, 8'h05};
        v[5] = '{6'h01, 32'h0,         32'h0,         32'h0,         8'h02};
        v[6] = '{6'h03, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 8'h04};
        v[7] = '{6'h03, 32'h0,         32'hABCD_EF01, 32'hABCD_EF01, 8'h08};
        v[8] = '{6'h05, 32'h0,         32'h0,         32'hFFFF_FFFF, 8'h04};
        v[9] = '{6'h02, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0,         8'h02};
        for (int i = 0; i < 10; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 8'h00);
            checks++;
            if (result !== v[i].r || flags_out !== v[i].f) begin
                failures++;
                $display("FAIL arith_logic[%0d]: result=%h flags=%h required %h/%h",
                         i, result, flags_out, v[i].r, v[i].f);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[6];
        v[0] = '{6'h06, 32'h8000_0000, 32'd1, 32'h0,         8'h03};
        v[1] = '{6'h07, 32'h8000_0000, 32'd1, 32'h4000_0000, 8'h00};
        v[2] = '{6'h07, 32'd3,         32'd1, 32'd1,         8'h01};
        v[3] = '{6'h0C, 32'hF000_0000, 32'd4, 32'hFF00_0000, 8'h04};
        v[4] = '{6'h06, 32'h8000_0001, 32'd0, 32'h8000_0001, 8'h08};
        v[5] = '{6'h06, 32'h0000_0003, 32'h21, 32'h6,        8'h00};
        for (int i = 0; i < 6; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 8'h00);
            checks++;
            if (result !== v[i].r || flags_out !== v[i].f) begin
                failures++;
                $display("FAIL shift[%0d]: result=%h flags=%h required %h/%h",
                         i, result, flags_out, v[i].r, v[i].f);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t v[9];
        v[0] = '{6'h08, 32'd7,           32'd6,         32'd42,        8'h00};
        v[1] = '{6'h09, 32'd42,          32'd0,         32'hFFFF_FFFF, 8'h05};
        v[2] = '{6'h09, 32'hFFFF_FFF6,   32'd2,         32'hFFFF_FFFB, 8'h04};
        v[3] = '{6'h0A, 32'd43,          32'd6,         32'd1,         8'h00};
        v[4] = '{6'h0A, 32'd43,          32'd0,         32'h0,         8'h03};
        v[5] = '{6'h09, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 8'h08};
        v[6] = '{6'h0A, 32'h8000_0000,   32'hFFFF_FFFF, 32'h0,         8'h02};
        v[7] = '{6'h08, 32'h0001_0000,   32'h0001_0001, 32'h0001_0000, 8'h01};
        v[8] = '{6'h0A, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, 8'h04};
        for (int i = 0; i < 9; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 8'h00);
            checks++;
            if (result !== v[i].r || flags_out !== v[i].f) begin
                failures++;
                $display("FAIL muldiv[%0d]: result=%h flags=%h required %h/%h",
                         i, result, flags_out, v[i].r, v[i].f);
            end
        end
    endtask

    task automatic test_cmp();
        vec_t v[4];
        v[0] = '{6'h0B, 32'd10,        32'd10, 32'd10,        8'hF0};
        v[1] = '{6'h0B, 32'd5,         32'd10, 32'd5,         8'hF1};
        v[2] = '{6'h0B, 32'hFFFF_FFFF, 32'd1,  32'hFFFF_FFFF, 8'hF1};
        v[3] = '{6'h0B, 32'd15,        32'd10, 32'd15,        8'hF0};
        for (int i = 0; i < 4; i++) begin
            drive(v[i].op, v[i].a, v[i].b, 8'hFF);
            checks++;
            if (result !== v[i].r || flags_out !== v[i].f) begin
                failures++;
                $display("FAIL cmp[%0d]: result=%h flags=%h required %h/%h",
                         i, result, flags_out, v[i].r, v[i].f);
            end
        end
    endtask

    task automatic test_undef();
        drive(6'h20, 32'h1234_5678, 32'h9ABC_DEF0, 8'hA5);
        checks++;
        if (result !== 32'h0 || flags_out !== 8'hA5) begin
            failures++;
            $display("FAIL undef_20: result=%h flags=%h required 00000000/a5", result, flags_out);
        end
        drive(6'h0D, 32'hFFFF_FFFF, 32'h1, 8'h3C);
        checks++;
        if (result !== 32'h0 || flags_out !== 8'h3C) begin
            failures++;
            $display("FAIL undef_0d: result=%h flags=%h required 00000000/3c", result, flags_out);
        end
        drive(6'h00, 32'hFFFF_FFFF, 32'h1, 8'hA5);
        checks++;
        if (flags_out !== 8'hA3) begin
            failures++;
            $display("FAIL upper_passthru: flags=%h required a3", flags_out);
        end
    endtask

    task automatic test_back_to_back();
        drive(6'h00, 32'd10, 32'd5, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd15 || flags_q !== 8'h00) begin
            failures++;
            $display("FAIL pipe_first: result_q=%h flags_q=%h required 0000000f/00", result_q, flags_q);
        end
        drive(6'h00, 32'hFFFF_FFFF, 32'h1, 8'h00);
        checks++;
        if (result_q !== 32'd15) begin
            failures++;
            $display("FAIL pipe_hold: result_q=%h required 0000000f", result_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h0 || flags_q !== 8'h03) begin
            failures++;
            $display("FAIL pipe_second: result_q=%h flags_q=%h required 00000000/03", result_q, flags_q);
        end
        drive(6'h08, 32'd7, 32'd6, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd42) begin
            failures++;
            $display("FAIL pipe_pre_reset: result_q=%h required 0000002a", result_q);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result_q !== 32'h0 || flags_q !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: result_q=%h flags_q=%h required 00000000/00", result_q, flags_q);
        end
        checks++;
        if (result !== 32'd42) begin
            failures++;
            $display("FAIL comb_in_reset: result=%h required 0000002a", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: result_q=%h required 00000000", result_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'h01, 32'h0, 32'h1, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'hFFFF_FFFF || flags_q !== 8'h05) begin
            failures++;
            $display("FAIL post_release: result_q=%h flags_q=%h required ffffffff/05", result_q, flags_q);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        flags_in = '0;
        test_reset();
        test_add_sub_logic();
        test_shift();
        test_muldiv();
        test_cmp();
        test_undef();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit integer ALU for the CPU datapath. Arithmetic, logic, shift, multiply, signed divide/modulo and signed compare.
- Result and flags are purely combinational from a, b and op.
- A registered copy of both is provided for pipelined consumers.

Parameters:
- None. Data width is fixed at 32 bits; flags width is fixed at 8 bits.

Ports:
- clk  input  1  system clock; rising edge updates registered outputs only
- rst_n  input  1  asynchronous active-low reset
- a  input  32  operand A
- b  input  32  operand B; shifts use b[4:0] as the shift count
- op  input  6  operation select
- flags_in  input  8  incoming flags
- result  output  32  combinational result
- flags_out  output  8  combinational flags: bit0 C, bit1 Z, bit2 N, bit3 V, bits 7:4 = flags_in[7:4]
- result_q  output  32  result registered on clk
- flags_q  output  8  flags_out registered on clk

Behaviour:
- Opcodes: 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 NOT(a), 06 SHL, 07 SHR (logical), 08 MUL, 09 DIV, 0A MOD, 0B CMP, 0C SAR.
- Default flag rules, used by every opcode except CMP and undefined opcodes:
  - Z = (result == 0)
  - N = result[31] & result[30]
  - V = result[31] & ~result[30]
  - These N/V definitions are mandatory for all ops, e.g. 0x80000000 gives V=1, N=0.
- C per op:
  - ADD: carry out of bit 31.
  - SUB (a-b): borrow, i.e. a < b unsigned.
  - AND / OR / XOR / NOT: 0.
  - SHL: last bit shifted out, a[32-n]. 0 when n = 0.
  - SHR / SAR: last bit shifted out, a[n-1]. 0 when n = 0.
  - MUL: 1 if the upper 32 bits of the 64-bit unsigned product are nonzero. Result is the low 32 bits.
  - DIV / MOD with b != 0: 0.
- DIV / MOD are signed, with truncation toward zero. MOD takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF: DIV result 0x80000000, MOD result 0, C=0.
- Divide by zero:
  - DIV: result 0xFFFFFFFF, C=1; other flags per default rules (N=1).
  - MOD: result 0, C=1, Z=1.
- CMP:
  - result = a.
  - C = signed(a) < signed(b).
  - Z, N, V are forced to 0, including when a == b.
- Undefined opcodes (0x0D–0x3F): result = 0, flags_out = flags_in.
- flags_out[7:4] always equals flags_in[7:4].
- Latency:
  - result and flags_out settle combinationally in the same cycle; no clock dependence.
  - result_q and flags_q capture result and flags_out on every rising clk edge, so they lag by 1 cycle.
- Reset: while rst_n = 0, asynchronously result_q = 0 and flags_q = 0. Combinational outputs are unaffected by reset.
- No X propagation: every opcode, including undefined ones, drives all output bits.

Test Plan:
- ADD:
  - 0xFFFFFFFF+1 -> 0, flags 0x03.
  - 0x7FFFFFFF+1 -> 0x80000000, flags 0x08.
  - 0x80000000+0xFFFFFFFF -> 0x7FFFFFFF, flags 0x01.
  - 10+5 -> 15, flags 0x00.
- SUB / logic:
  - 0-1 -> 0xFFFFFFFF, flags 0x05; 0-0 -> 0, flags 0x02.
  - 0xF0F0F0F0 OR 0x0F0F0F0F -> 0xFFFFFFFF, flags 0x04.
  - 0 OR 0xABCDEF01 -> 0xABCDEF01, flags 0x08.
  - NOT 0 -> 0xFFFFFFFF, flags 0x04.
- Shifts:
  - SHL 0x80000000 by 1 -> 0, flags 0x03.
  - SHR 0x80000000 by 1 -> 0x40000000, flags 0x00.
  - SHR 3 by 1 -> 1, flags 0x01.
  - SAR 0xF0000000 by 4 -> 0xFF000000, flags 0x04.
- MUL / DIV / MOD:
  - 7*6 -> 42, flags 0x00.
  - 42/0 -> 0xFFFFFFFF, flags 0x05.
  - -10/2 -> 0xFFFFFFFB, flags 0x04.
  - 43%6 -> 1, flags 0x00.
  - 43%0 -> 0, flags 0x03.
- CMP:
  - 10 vs 10 -> result 10, flags 0x00.
  - 5 vs 10 -> result 5, flags 0x01.
  - 0xFFFFFFFF vs 1 -> result 0xFFFFFFFF, flags 0x01.
  - 15 vs 10 -> result 15, flags 0x00.
- Clocking and passthrough:
  - Assert rst_n=0 mid-run -> result_q and flags_q go to 0 immediately, without a clock edge.
  - After release, result_q and flags_q equal the previous cycle's result and flags_out.
  - Undefined op 0x20 with flags_in=0xA5 -> result 0, flags_out 0xA5.
